// File: rtl/decode_stage.sv
// RV32I decode stage: combinational field/immediate/unit decode, registered through a
// two-entry skid buffer. Optional illegal-instruction checking under `DECODE_ILLEGAL_EN.
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [2:0]  out_funct3,
    output logic        out_alt,
    output logic [31:0] out_imm,
    output logic [3:0]  out_unit,
    output logic        out_use_imm,
    output logic        out_reg_write,
    output logic        out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [3:0] UNIT_NONE    = 4'd0;
    localparam logic [3:0] UNIT_ARITH   = 4'd1;
    localparam logic [3:0] UNIT_LOGICAL = 4'd2;
    localparam logic [3:0] UNIT_SHIFT   = 4'd3;
    localparam logic [3:0] UNIT_BRANCH  = 4'd4;
    localparam logic [3:0] UNIT_LOAD    = 4'd5;
    localparam logic [3:0] UNIT_STORE   = 4'd6;
    localparam logic [3:0] UNIT_JAL     = 4'd7;
    localparam logic [3:0] UNIT_JALR    = 4'd8;
    localparam logic [3:0] UNIT_LUI     = 4'd9;
    localparam logic [3:0] UNIT_AUIPC   = 4'd10;
    localparam logic [3:0] UNIT_SYSTEM  = 4'd11;
    localparam logic [3:0] UNIT_FENCE   = 4'd12;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic        alt;
        logic [31:0] imm;
        logic [3:0]  unit;
        logic        use_imm;
        logic        reg_write;
        logic        illegal;
    } entry_t;

    function automatic logic [3:0] alu_unit(input logic [2:0] f3);
        logic [3:0] u;
        case (f3)
            3'b000, 3'b010, 3'b011: u = UNIT_ARITH;
            3'b100, 3'b110, 3'b111: u = UNIT_LOGICAL;
            3'b001, 3'b101:         u = UNIT_SHIFT;
            default:                u = UNIT_NONE;
        endcase
        return u;
    endfunction

    logic [6:0]  opcode_s;
    logic [6:0]  funct7_s;
    logic [2:0]  funct3_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    entry_t      dec_s;

    state_e      state_q, state_d;
    entry_t      main_q, main_d;
    entry_t      skid_q, skid_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        in_xfer_s, out_xfer_s;

    assign opcode_s = in_instr[6:0];
    assign funct7_s = in_instr[31:25];
    assign funct3_s = in_instr[14:12];

    assign imm_i_s = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b_s = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                      in_instr[11:8], 1'b0};
    assign imm_u_s = {in_instr[31:12], 12'h000};
    assign imm_j_s = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                      in_instr[30:21], 1'b0};

    // Instruction decode into a candidate entry
    always_comb begin
        dec_s           = '0;
        dec_s.pc        = in_pc;
        dec_s.rd        = in_instr[11:7];
        dec_s.rs1       = in_instr[19:15];
        dec_s.rs2       = in_instr[24:20];
        dec_s.funct3    = funct3_s;
        dec_s.alt       = in_instr[30];
        dec_s.imm       = 32'd0;
        dec_s.unit      = UNIT_NONE;
        dec_s.use_imm   = 1'b0;
        dec_s.reg_write = 1'b0;
        dec_s.illegal   = 1'b0;
        case (opcode_s)
            OPC_OP:     dec_s.unit = alu_unit(funct3_s);
            OPC_OP_IMM: begin
                dec_s.unit    = alu_unit(funct3_s);
                dec_s.use_imm = 1'b1;
                dec_s.imm     = imm_i_s;
            end
            OPC_BRANCH: begin
                dec_s.unit = UNIT_BRANCH;
                dec_s.imm  = imm_b_s;
            end
            OPC_LOAD: begin
                dec_s.unit    = UNIT_LOAD;
                dec_s.use_imm = 1'b1;
                dec_s.imm     = imm_i_s;
            end
            OPC_STORE: begin
                dec_s.unit    = UNIT_STORE;
                dec_s.use_imm = 1'b1;
                dec_s.imm     = imm_s_s;
            end
            OPC_JAL: begin
                dec_s.unit = UNIT_JAL;
                dec_s.imm  = imm_j_s;
            end
            OPC_JALR: begin
                dec_s.unit    = UNIT_JALR;
                dec_s.use_imm = 1'b1;
                dec_s.imm     = imm_i_s;
            end
            OPC_LUI: begin
                dec_s.unit = UNIT_LUI;
                dec_s.imm  = imm_u_s;
            end
            OPC_AUIPC: begin
                dec_s.unit = UNIT_AUIPC;
                dec_s.imm  = imm_u_s;
            end
            OPC_SYSTEM: begin
                dec_s.unit = UNIT_SYSTEM;
                dec_s.imm  = imm_i_s;
            end
            OPC_FENCE: dec_s.unit = UNIT_FENCE;
            default:   dec_s.unit = UNIT_NONE;
        endcase
`ifdef DECODE_ILLEGAL_EN
        dec_s.illegal = (in_instr[1:0] != 2'b11)
            || (dec_s.unit == UNIT_NONE)
            || ((opcode_s == OPC_OP) && (funct7_s != 7'b0000000) && (funct7_s != 7'b0100000))
            || ((opcode_s == OPC_OP) && (funct7_s == 7'b0100000)
                && (funct3_s != 3'b000) && (funct3_s != 3'b101))
            || ((opcode_s == OPC_OP_IMM) && (funct3_s == 3'b001) && (funct7_s != 7'b0000000))
            || ((opcode_s == OPC_OP_IMM) && (funct3_s == 3'b101)
                && (funct7_s != 7'b0000000) && (funct7_s != 7'b0100000));
        if (dec_s.illegal) begin
            dec_s.unit = UNIT_NONE;
        end else begin
            dec_s.unit = dec_s.unit;
        end
`else
        dec_s.illegal = 1'b0;
`endif
        case (dec_s.unit)
            UNIT_ARITH, UNIT_LOGICAL, UNIT_SHIFT, UNIT_LOAD,
            UNIT_JAL, UNIT_JALR, UNIT_LUI, UNIT_AUIPC:
                dec_s.reg_write = (dec_s.rd != 5'd0) && !dec_s.illegal;
            default:
                dec_s.reg_write = 1'b0;
        endcase
    end

    assign in_xfer_s  = in_valid && in_ready_q;
    assign out_xfer_s = out_valid_q && out_ready;

    // Skid buffer next-state and entry movement; flush overrides everything
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        main_d  = dec_s;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        main_d = dec_s;
                    end else if (in_xfer_s) begin
                        skid_d  = dec_s;
                        state_d = ST_TWO;
                    end else if (out_xfer_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (out_xfer_s) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // State, handshake flags and entry registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_pc        = main_q.pc;
    assign out_rd        = main_q.rd;
    assign out_rs1       = main_q.rs1;
    assign out_rs2       = main_q.rs2;
    assign out_funct3    = main_q.funct3;
    assign out_alt       = main_q.alt;
    assign out_imm       = main_q.imm;
    assign out_unit      = main_q.unit;
    assign out_use_imm   = main_q.use_imm;
    assign out_reg_write = main_q.reg_write;
    assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode fields, backpressure, flush, reset.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] in_instr, in_pc;
    logic [31:0] out_pc, out_imm;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic        out_alt, out_use_imm, out_reg_write, out_illegal;
    logic [3:0]  out_unit;
    int          total = 0;
    int          bad = 0;

    decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
        .out_alt(out_alt), .out_imm(out_imm), .out_unit(out_unit),
        .out_use_imm(out_use_imm), .out_reg_write(out_reg_write), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dec(input string tag, input logic [3:0] unit, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm, input logic use_imm, input logic reg_write,
                           input logic alt);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".unit"}, 32'(out_unit), 32'(unit));
        chk({tag, ".funct3"}, 32'(out_funct3), 32'(f3));
        chk({tag, ".rd"}, 32'(out_rd), 32'(rd));
        chk({tag, ".rs1"}, 32'(out_rs1), 32'(rs1));
        chk({tag, ".rs2"}, 32'(out_rs2), 32'(rs2));
        chk({tag, ".imm"}, out_imm, imm);
        chk({tag, ".use_imm"}, 32'(out_use_imm), 32'(use_imm));
        chk({tag, ".reg_write"}, 32'(out_reg_write), 32'(reg_write));
        chk({tag, ".alt"}, 32'(out_alt), 32'(alt));
    endtask

    // Present one instruction for a single cycle with out_ready high
    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'd0; in_pc = 32'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_pc", out_pc, 32'd0);
        chk("rst.out_imm", out_imm, 32'd0);
        chk("rst.out_unit", 32'(out_unit), 32'd0);
        chk("rst.out_rd", 32'(out_rd), 32'd0);
        chk("rst.out_illegal", 32'(out_illegal), 32'd0);

        send(32'h0020C1B3, 32'h100);
        chk_dec("xor", 4'd2, 3'b100, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("xor.pc", out_pc, 32'h100);
        send(32'hFFF0E093, 32'h104);
        chk_dec("ori", 4'd2, 3'b110, 5'd1, 5'd1, 5'd31, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1);
        chk("ori.pc", out_pc, 32'h104);
        send(32'h00112223, 32'h108);
        chk_dec("sw", 4'd6, 3'b010, 5'd4, 5'd2, 5'd1, 32'd4, 1'b1, 1'b0, 1'b0);
        send(32'h123450B7, 32'h10C);
        chk_dec("lui", 4'd9, 3'b101, 5'd1, 5'd8, 5'd3, 32'h12345000, 1'b0, 1'b1, 1'b0);
        send(32'hFE000EE3, 32'h110);
        chk_dec("beq", 4'd4, 3'b000, 5'd29, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b1);
        send(32'h008000EF, 32'h114);
        chk_dec("jal", 4'd7, 3'b000, 5'd1, 5'd0, 5'd8, 32'd8, 1'b0, 1'b1, 1'b0);
        send(32'h00000013, 32'h118);
        chk_dec("addi0", 4'd1, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        send(32'h4020C1B3, 32'h11C);
`ifdef DECODE_ILLEGAL_EN
        chk_dec("ill", 4'd0, 3'b100, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("ill.illegal", 32'(out_illegal), 32'd1);
`else
        chk_dec("ill", 4'd2, 3'b100, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 1'b1);
        chk("ill.illegal", 32'(out_illegal), 32'd0);
`endif
        tick();
        chk("drain.out_valid", 32'(out_valid), 32'd0);

        // Backpressure: three back-to-back with downstream stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00000013; in_pc = 32'h200;
        tick();
        chk("bp1.in_ready", 32'(in_ready), 32'd1);
        in_instr = 32'h00100093; in_pc = 32'h204;
        tick();
        chk("bp2.in_ready", 32'(in_ready), 32'd0);
        chk("bp2.out_pc", out_pc, 32'h200);
        in_instr = 32'h00200113; in_pc = 32'h208;
        tick();
        chk("bp3.in_ready", 32'(in_ready), 32'd0);
        chk("bp3.hold_pc", out_pc, 32'h200);
        chk("bp3.hold_rd", 32'(out_rd), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("bp4.out_pc", out_pc, 32'h204);
        chk("bp4.out_rd", 32'(out_rd), 32'd1);
        chk("bp4.in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp5.out_pc", out_pc, 32'h208);
        chk("bp5.out_rd", 32'(out_rd), 32'd2);
        chk("bp5.out_valid", 32'(out_valid), 32'd1);
        tick();
        chk("bp6.out_valid", 32'(out_valid), 32'd0);
        chk("bp6.in_ready", 32'(in_ready), 32'd1);

        // Flush while holding two entries, with an input offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00300193; in_pc = 32'h300;
        tick();
        in_pc = 32'h304;
        tick();
        chk("fl.pre_in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1;
        in_pc = 32'h308;
        tick();
        chk("fl.out_valid", 32'(out_valid), 32'd0);
        chk("fl.in_ready", 32'(in_ready), 32'd1);
        in_pc = 32'h30C;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        chk("fl.dropped", 32'(out_valid), 32'd0);
        send(32'h00400213, 32'h400);
        chk("fl.after_pc", out_pc, 32'h400);
        chk("fl.after_rd", 32'(out_rd), 32'd4);

        // Reset with both entries full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h500;
        tick(); tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2.out_valid", 32'(out_valid), 32'd0);
        chk("rst2.in_ready", 32'(in_ready), 32'd1);
        chk("rst2.out_pc", out_pc, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
